weight_mem_loader: RTL and testbench
====================================

// Module: weight_mem_loader
// PURPOSE
//  Write-side counterpart of the per-neuron weight ROM/RAM: accepts a valid/ready word stream of packed weights,
//  filters words by (layer, neuron) tag, unpacks two weights per 32-bit word and drives wen/waddr/win of one
//  neuron's weight memory. Sits between the AXI config/DMA front end and each neuron's weight memory.
// PARAMETERS
//  dataWidth     16   weight width; must be <=16 (two weights per 32-bit word)
//  addressWidth  10   weight memory address width; waddr is addressWidth+1 bits, matching the memory read port
//  numWeight     784  weights per neuron; load completes after this many writes
//  layerNo       1    layer id this instance answers to
//  neuronNo      0    neuron id this instance answers to
// PORTS
//  clk        in   1                single clock, all logic on posedge
//  rst_n      in   1                synchronous reset, active-low
//  s_valid    in   1                stream word valid
//  s_ready    out  1                loader can accept a word this cycle
//  s_data     in   32               [dataWidth-1:0]=weight n, [16+dataWidth-1:16]=weight n+1
//  s_layer    in   8                target layer tag of s_data
//  s_neuron   in   8                target neuron tag of s_data
//  s_last     in   1                final word of this neuron's weight block
//  wen        out  1                weight memory write enable
//  waddr      out  addressWidth+1   write address
//  win        out  dataWidth        write data
//  busy       out  1                load in progress (first matching word accepted, not yet done)
//  load_done  out  1                1-cycle pulse: numWeight weights written
//  load_err   out  1                1-cycle pulse: s_last arrived before numWeight weights written
// BEHAVIOUR
//  Reset: state=IDLE, s_ready=0 during reset then 1, wen=0, waddr=0, win=0, busy=0, load_done=0, load_err=0, count=0.
//  Handshake: word transferred when s_valid&&s_ready. s_data/tags/s_last must hold while s_valid&&!s_ready.
//  Tag filter: transferred word with s_layer!=layerNo or s_neuron!=neuronNo is consumed and dropped, no write.
//  FSM  IDLE -> LO on matching transfer; LO -> HI always; HI -> IDLE (s_ready=1 again).
//   LO (cycle after transfer): wen=1, waddr=count, win=low half; count++; busy=1.
//   HI: if count<numWeight: wen=1, waddr=count, win=high half, count++; else high half discarded (odd numWeight).
//   s_ready=0 in LO and HI -> max throughput 1 word / 3 cycles (2 writes).
//  Completion: when count reaches numWeight on a write, load_done pulses with that write's cycle+1; count and waddr
//   return to 0, busy=0; further matching words restart a new load from address 0 (reload overwrites).
//  Early last: matching word with s_last=1 whose writes leave count<numWeight -> load_err pulses cycle after HI,
//   count=0, busy=0; written entries are not cleared.
//  Late last: s_last on the completing word is ignored; s_last=0 on the completing word is not an error.
//  Simultaneous done and err never both asserted; done has priority.
//  wen is 0 in every cycle not listed above; waddr/win hold last value when wen=0.
//  rst_n low mid-load: abandon immediately, all outputs to reset values next edge, no done/err pulse.
// CONFIGURATION
//  WEIGHT_CHECKSUM_EN defined: adds output chk[15:0]; cleared at reset and at start of each load, sums
//   zero-extended win on every write (mod 2^16); value is stable and valid in the load_done pulse cycle.
//  Not defined: no chk port, no adder; all other behaviour identical.
// STRUCTURE
//  Shared package/include: FSM state encodings (IDLE/LO/HI), tag width constant (8), stream word width (32).
//  One natural sub-module: weight_unpack (captures word, muxes low/high half onto win); FSM+counter in top.
// TESTING
//  numWeight=4, matching words 0x0002_0001,0x0004_0003 -> writes (0,1),(1,2),(2,3),(3,4); load_done 1 pulse; busy 0.
//  Word tagged neuronNo+1 -> s_ready pulse consumed, wen stays 0, count unchanged.
//  numWeight=3, words 0x0002_0001,0x0004_0003 -> 3 writes, value 4 never written, load_done once.
//  numWeight=4, one word with s_last=1 -> 2 writes, then load_err pulse, count=0, no load_done.
//  s_valid held high continuously -> s_ready pattern 1,0,0 repeating; rst_n low in LO -> wen=0, waddr=0 next cycle.
//  WEIGHT_CHECKSUM_EN: weights 0xFFFF,0x0002 (numWeight=2) -> chk=0x0001 at load_done.

Source files
------------

// File: rtl/weight_mem_loader_pkg.sv
// Shared definitions for the weight memory loader: loader FSM states and stream/tag widths.
package weight_mem_loader_pkg;

  localparam int TAG_W  = 8;
  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

endpackage

// File: rtl/weight_mem_loader_unpack.sv
// weight_unpack: holds the high half of an accepted word and drives the registered write-data bus.
module weight_unpack
  import weight_mem_loader_pkg::*;
#(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_capture,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic [WORD_W-1:0]    i_word,
  output logic [dataWidth-1:0] o_wdata_next,
  output logic [dataWidth-1:0] o_win
);

  logic [dataWidth-1:0] r_hi;
  logic [dataWidth-1:0] r_win;

  // Low half is written on the accept edge straight from the stream; only the high half needs holding.
  always_comb begin
    o_wdata_next = i_word[dataWidth-1:0];
    if (i_wr_hi) o_wdata_next = r_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi  <= '0;
      r_win <= '0;
    end else begin
      if (i_capture) r_hi <= i_word[HALF_W +: dataWidth];
      if (i_wr_lo || i_wr_hi) r_win <= o_wdata_next;
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/weight_mem_loader.sv
// Tag-filtered weight stream loader: two weights per 32-bit word into one neuron's weight memory.
// Optional running checksum output chk enabled by defining WEIGHT_CHECKSUM_EN.
module weight_mem_loader
  import weight_mem_loader_pkg::*;
#(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10,
  parameter int numWeight    = 784,
  parameter int layerNo      = 1,
  parameter int neuronNo     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WORD_W-1:0]       s_data,
  input  logic [TAG_W-1:0]        s_layer,
  input  logic [TAG_W-1:0]        s_neuron,
  input  logic                    s_last,
  output logic                    wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
`ifdef WEIGHT_CHECKSUM_EN
  ,
  output logic [15:0]             chk
`endif
);

  localparam int CNT_W  = $clog2(numWeight + 1);
  localparam int ADDR_W = addressWidth + 1;
  localparam logic [CNT_W-1:0] NW = CNT_W'(numWeight);

  state_t              r_state;
  logic                r_ready;
  logic                r_wen;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_last;
  logic [ADDR_W-1:0]   r_waddr;
  logic [CNT_W-1:0]    r_count;

  logic                w_match;
  logic                w_xfer;
  logic                w_wr_lo;
  logic                w_wr_hi;
  logic [dataWidth-1:0] w_wdata;

  assign w_match = (s_layer == TAG_W'(layerNo)) && (s_neuron == TAG_W'(neuronNo));
  assign w_xfer  = s_valid && r_ready;
  assign w_wr_lo = (r_state == IDLE) && w_xfer && w_match;
  assign w_wr_hi = (r_state == LO) && (r_count < NW);

  weight_unpack #(
    .dataWidth(dataWidth)
  ) u_unpack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_wr_lo),
    .i_wr_lo     (w_wr_lo),
    .i_wr_hi     (w_wr_hi),
    .i_word      (s_data),
    .o_wdata_next(w_wdata),
    .o_win       (win)
  );

  // State names the cycle in which the corresponding write is presented on wen/waddr/win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_waddr <= '0;
      r_count <= '0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_wr_lo) begin
            r_state <= LO;
            r_ready <= 1'b0;
            r_wen   <= 1'b1;
            r_waddr <= ADDR_W'(r_count);
            r_count <= r_count + CNT_W'(1);
            r_busy  <= 1'b1;
            r_last  <= s_last;
          end
        end
        LO: begin
          r_state <= HI;
          if (w_wr_hi) begin
            r_wen   <= 1'b1;
            r_waddr <= ADDR_W'(r_count);
            r_count <= r_count + CNT_W'(1);
          end else begin
            // Odd block: the low-half write completed the load, high half is dropped.
            r_done  <= 1'b1;
            r_count <= '0;
            r_waddr <= '0;
            r_busy  <= 1'b0;
          end
        end
        HI: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          if (r_count == NW) begin
            r_done  <= 1'b1;
            r_count <= '0;
            r_waddr <= '0;
            r_busy  <= 1'b0;
          end else if (r_busy && r_last) begin
            r_err   <= 1'b1;
            r_count <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready   = r_ready;
  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign busy      = r_busy;
  assign load_done = r_done;
  assign load_err  = r_err;

`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] r_chk;
  logic [15:0] w_wd16;

  assign w_wd16 = 16'(w_wdata);

  // First write of a load (count still 0) restarts the sum instead of accumulating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (w_wr_lo && (r_count == '0)) begin
      r_chk <= w_wd16;
    end else if (w_wr_lo || w_wr_hi) begin
      r_chk <= r_chk + w_wd16;
    end
  end

  assign chk = r_chk;
`endif

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: two instances (numWeight 4 and 3) share one randomized stream.
module tb_weight_mem_loader;

  localparam int LAYER  = 1;
  localparam int NEURON = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic [7:0]  s_layer = '0;
  logic [7:0]  s_neuron = '0;
  logic        s_last = 1'b0;

  logic        s_ready0, wen0, busy0, done0, err0;
  logic        s_ready1, wen1, busy1, done1, err1;
  logic [10:0] waddr0, waddr1;
  logic [15:0] win0, win1;
  logic [15:0] chk0, chk1;

  always #5 clk = ~clk;

  weight_mem_loader #(.dataWidth(16), .addressWidth(10), .numWeight(4), .layerNo(LAYER), .neuronNo(NEURON)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_layer(s_layer), .s_neuron(s_neuron), .s_last(s_last), .wen(wen0), .waddr(waddr0),
    .win(win0), .busy(busy0), .load_done(done0), .load_err(err0)
`ifdef WEIGHT_CHECKSUM_EN
    , .chk(chk0)
`endif
  );

  weight_mem_loader #(.dataWidth(16), .addressWidth(10), .numWeight(3), .layerNo(LAYER), .neuronNo(NEURON)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_layer(s_layer), .s_neuron(s_neuron), .s_last(s_last), .wen(wen1), .waddr(waddr1),
    .win(win1), .busy(busy1), .load_done(done1), .load_err(err1)
`ifdef WEIGHT_CHECKSUM_EN
    , .chk(chk1)
`endif
  );

`ifndef WEIGHT_CHECKSUM_EN
  assign chk0 = '0;
  assign chk1 = '0;
`endif

  // kind: 0 write, 1 load_done, 2 load_err
  typedef struct {
    int kind;
    int addr;
    int data;
    int sum;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  mcount[2];
  int  msum[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int kind, input int addr, input int data, input int sum);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.sum = sum;
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference: a block of nw weights, two per word, low half first; s_last short of nw is an error.
  task automatic model_word(input logic [31:0] d, input logic [7:0] l, input logic [7:0] n, input logic last);
    int w[2];
    int nw;
    bit ended;
    if (l != 8'(LAYER) || n != 8'(NEURON)) return;
    w[0] = int'(d[15:0]);
    w[1] = int'(d[31:16]);
    for (int idx = 0; idx < 2; idx++) begin
      nw = (idx == 0) ? 4 : 3;
      ended = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!ended) begin
          if (mcount[idx] == 0) msum[idx] = 0;
          msum[idx] = (msum[idx] + w[k]) % 65536;
          push(idx, 0, mcount[idx], w[k], 0);
          mcount[idx]++;
          if (mcount[idx] == nw) begin
            push(idx, 1, 0, 0, msum[idx]);
            mcount[idx] = 0;
            ended = 1'b1;
          end
        end
      end
      if (!ended && last) begin
        push(idx, 2, 0, 0, 0);
        mcount[idx] = 0;
      end
    end
  endtask

  task automatic mon(input int idx, input logic wen, input logic [10:0] waddr, input logic [15:0] win,
                     input logic done, input logic err, input logic busy, input logic [15:0] chk);
    ev_t e;
    int kind;
    string tag;
    tag = (idx == 0) ? "nw4" : "nw3";
    if (wen || done || err) begin
      check({tag, "_one_event"}, 32'(int'(wen) + int'(done) + int'(err)), 32'd1);
      kind = wen ? 0 : (done ? 1 : 2);
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got event kind %0d expected none", tag, kind);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        check({tag, "_kind"}, 32'(kind), 32'(e.kind));
        if (e.kind == 0 && kind == 0) begin
          check({tag, "_waddr"}, 32'(waddr), 32'(e.addr));
          check({tag, "_win"}, 32'(win), 32'(e.data));
          check({tag, "_busy_wr"}, 32'(busy), 32'd1);
        end else if (e.kind == 1 && kind == 1) begin
          check({tag, "_waddr_done"}, 32'(waddr), 32'd0);
          check({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef WEIGHT_CHECKSUM_EN
          check({tag, "_chk"}, 32'(chk), 32'(e.sum));
`endif
        end else if (e.kind == 2 && kind == 2) begin
          check({tag, "_busy_err"}, 32'(busy), 32'd0);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon(0, wen0, waddr0, win0, done0, err0, busy0, chk0);
        mon(1, wen1, waddr1, win1, done1, err1, busy1, chk1);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [7:0] l, input logic [7:0] n, input logic last,
                      output int waits);
    bit got;
    s_valid = 1'b1; s_data = d; s_layer = l; s_neuron = n; s_last = last;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 20) begin
      @(negedge clk);
      waits++;
      if (s_ready0 === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got no ready in %0d cycles expected ready", waits);
    end else begin
      @(posedge clk);
      #1;
      model_word(d, l, n, last);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    logic [7:0] l, n;
    mcount[0] = 0; mcount[1] = 0; msum[0] = 0; msum[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready0), 32'd0);
    check("rst_wen", 32'(wen0), 32'd0);
    check("rst_waddr", 32'(waddr0), 32'd0);
    check("rst_win", 32'(win0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done_err", 32'({done0, err0}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 32'(s_ready0), 32'd1);

    // Two words: full load for nw4, odd load (high 4 dropped) for nw3.
    send(32'h0002_0001, 8'(LAYER), 8'(NEURON), 1'b0, w);
    send(32'h0004_0003, 8'(LAYER), 8'(NEURON), 1'b0, w);
    idle(4);
    check("busy_after_load", 32'(busy0), 32'd0);

    // Foreign tags are consumed without writes.
    send(32'hDEAD_BEEF, 8'(LAYER), 8'(NEURON + 1), 1'b0, w);
    send(32'hCAFE_F00D, 8'(LAYER + 1), 8'(NEURON), 1'b1, w);
    idle(3);

    // Early last: one word then error.
    send(32'h0006_0005, 8'(LAYER), 8'(NEURON), 1'b1, w);
    idle(4);
    check("busy_after_err", 32'(busy0), 32'd0);

    // Checksum wrap: 0xFFFF + 0x0002 + 0 + 0 = 0x0001.
    send(32'h0002_FFFF, 8'(LAYER), 8'(NEURON), 1'b0, w);
    send(32'h0000_0000, 8'(LAYER), 8'(NEURON), 1'b1, w);
    idle(4);

    // Continuous valid: one accept every third cycle.
    for (int i = 0; i < 6; i++) begin
      send($urandom, 8'(LAYER), 8'(NEURON), 1'b0, w);
      if (i > 0) check("ready_spacing", 32'(w), 32'd3);
    end
    idle(4);

    // Reset during LO write cycle.
    send(32'h1234_5678, 8'(LAYER), 8'(NEURON), 1'b0, w);
    mon_en = 1'b0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_wen", 32'(wen0), 32'd0);
    check("midrst_waddr", 32'(waddr0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_done_err", 32'({done0, err0, done1, err1}), 32'd0);
    q0.delete(); q1.delete();
    mcount[0] = 0; mcount[1] = 0;
    rst_n = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // Randomized stream against the reference.
    for (int i = 0; i < 80; i++) begin
      l = ($urandom_range(0, 7) == 0) ? 8'(LAYER + 1) : 8'(LAYER);
      n = ($urandom_range(0, 7) == 0) ? 8'(NEURON + 2) : 8'(NEURON);
      send($urandom, l, n, ($urandom_range(0, 4) == 0), w);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(6);
    check("q_nw4_drained", 32'(q0.size()), 32'd0);
    check("q_nw3_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
